board_store: RTL and testbench
==============================

Name: board_store

Overview:
- Authoritative 4x4 tile register bank for the 2048 game.
- Sits at the other end of the control block's board interface:
  - consumes `update` / `newvalues`;
  - drives `oldvalues` back to control.
- Also provides a registered random-access read port and a sequential 16-tile scan stream for the display renderer.
- Maintains move statistics: change pulse, move count, empty-tile count and max tile.

Parameters:
- MOVE_W, 16, width of saturating move counter.
- INIT_BOARD, 64'h0, board value loaded on reset and on clear.

Ports:
- clock  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous active-low reset
- update  in  1  load-enable from control
- newvalues  in  64  candidate board; box1 in [63:60] … box16 in [3:0]; tile index i occupies [63-4i:60-4i]
- clear  in  1  synchronous board clear to INIT_BOARD; priority over update
- oldvalues  out  64  current stored board, same packing as newvalues
- board_changed  out  1  one-cycle pulse when a load altered the board
- move_count  out  MOVE_W  number of altering loads, saturating
- empty_count  out  5  number of zero tiles (0..16)
- max_tile  out  4  largest tile exponent on board
- rd_req  in  1  random read request
- rd_addr  in  4  tile index to read
- rd_valid  out  1  rd_data valid
- rd_data  out  4  tile value
- scan_start  in  1  begin 16-tile scan
- scan_busy  out  1  scan in progress
- scan_valid  out  1  scan_data valid this cycle
- scan_idx  out  4  index of scan_data
- scan_data  out  4  tile value
- scan_last  out  1  asserted with index 15
- undo  in  1  restore previous board (UNDO_EN only)

Behaviour:
- Reset (async, reset_n=0):
  - board=INIT_BOARD;
  - move_count=0; board_changed=0;
  - rd_valid=0; rd_data=0;
  - scan FSM=IDLE; scan outputs all 0;
  - empty_count/max_tile = values for INIT_BOARD (16/0 at default).
- oldvalues is the board register directly; zero-latency combinational view of the register.
- Load:
  - On a clock edge with update=1 and clear=0, board<=newvalues.
  - If newvalues != board, board_changed=1 the next cycle and move_count += 1, saturating at all-ones (no wrap).
  - Identical load: no pulse, no count.
- Clear: board<=INIT_BOARD; move_count<=0; board_changed<=0; scan aborts to IDLE.
- Statistics:
  - empty_count and max_tile are registered, computed from the board register.
  - They reflect a load one cycle after the board updates, i.e. two edges after the update edge.
- Read port:
  - rd_req sampled at an edge gives rd_valid=1 and rd_data=tile[rd_addr] after that edge.
  - rd_valid=0 otherwise.
  - Read and update at the same edge: returns the pre-update value.
  - Back-to-back reads: one result per cycle.
- Scan FSM, states IDLE, SCAN:
  - IDLE with scan_start=1 -> SCAN with idx=0.
  - SCAN:
    - each cycle, present scan_valid=1, scan_idx=idx, scan_data=snapshot[idx];
    - idx increments; scan_last=1 at idx 15;
    - after idx 15, -> IDLE.
  - scan_busy=1 in SCAN.
  - The board is snapshotted into a 64-bit scan register on scan entry; loads during a scan do not alter the streamed data.
  - scan_start while busy is ignored.
  - Exactly 16 valid beats per scan, contiguous, no gaps.

Optional Feature:
- Macro BOARD_STORE_UNDO_EN.
- When defined:
  - A previous-board register captures the old board on every altering load.
  - undo=1 (update=0, clear=0) restores the previous board once, decrements move_count (floor 0) and clears the undo-available flag.
  - A second undo without an intervening altering load is ignored.
  - Precedence: clear > update > undo.
- When not defined: the undo port is present but ignored; no previous-board register.

Test Plan:
- Reset with default INIT_BOARD -> oldvalues=0, empty_count=16, max_tile=0, move_count=0.
- update=1, newvalues=64'h1000_0000_0000_0002 -> next cycle oldvalues equals it and board_changed pulses 1 cycle; move_count=1. Two cycles later: empty_count=14, max_tile=2. Repeating the same load -> no pulse, count stays 1.
- rd_req, rd_addr=15 with update to 64'h…0005 at same edge -> rd_data=2 (old value). Next read of addr 15 returns 5.
- scan_start, then update mid-scan -> 16 beats, scan_idx 0..15, scan_data from the pre-scan board, scan_last only on idx 15. A second scan_start during the scan is ignored.
- Force move_count to all-ones via MOVE_W=2 and 4 altering loads -> count holds 3. clear during a scan -> board=INIT_BOARD, count=0, scan_busy=0 next cycle.
- UNDO_EN defined:
  - altering load A->B, then undo -> board=A, move_count decremented;
  - second undo -> no change;
  - undo without UNDO_EN -> no change.

Source files
------------

// File: rtl/board_store.sv
// board_store: authoritative 4x4 tile bank for 2048 with read port, scan stream and move statistics.
// Optional undo support is enabled by defining BOARD_STORE_UNDO_EN.
module board_store #(
  parameter int          MOVE_W     = 16,
  parameter logic [63:0] INIT_BOARD = 64'h0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              update,
  input  logic [63:0]       newvalues,
  input  logic              clear,
  output logic [63:0]       oldvalues,
  output logic              board_changed,
  output logic [MOVE_W-1:0] move_count,
  output logic [4:0]        empty_count,
  output logic [3:0]        max_tile,
  input  logic              rd_req,
  input  logic [3:0]        rd_addr,
  output logic              rd_valid,
  output logic [3:0]        rd_data,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_valid,
  output logic [3:0]        scan_idx,
  output logic [3:0]        scan_data,
  output logic              scan_last,
  input  logic              undo,
  output logic [0:0]        scan_state
);

  localparam logic [0:0]        S_IDLE = 1'b0;
  localparam logic [0:0]        S_SCAN = 1'b1;
  localparam logic [MOVE_W-1:0] ONE    = {{(MOVE_W-1){1'b0}}, 1'b1};
  localparam logic [MOVE_W-1:0] MAXC   = {MOVE_W{1'b1}};

  // Tile 0 lives in the top nibble, so shift left by idx nibbles and take the top.
  function automatic logic [3:0] tile_of(input logic [63:0] b, input logic [3:0] idx);
    logic [63:0] s;
    s = b << {idx, 2'b00};
    return s[63:60];
  endfunction

  function automatic logic [4:0] empty_of(input logic [63:0] b);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++)
      if (b[4*i +: 4] == 4'd0) n = n + 5'd1;
    return n;
  endfunction

  function automatic logic [3:0] max_of(input logic [63:0] b);
    logic [3:0] m;
    m = 4'd0;
    for (int i = 0; i < 16; i++)
      if (b[4*i +: 4] > m) m = b[4*i +: 4];
    return m;
  endfunction

  logic [63:0] board;
  logic [63:0] snap;
  logic [3:0]  scan_ptr;
  logic        altering;

  assign oldvalues = board;
  assign altering  = (newvalues != board);

`ifdef BOARD_STORE_UNDO_EN
  logic [63:0] prev_board;
  logic        undo_avail;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_board <= INIT_BOARD;
      undo_avail <= 1'b0;
    end else if (clear) begin
      undo_avail <= 1'b0;
    end else if (update) begin
      if (altering) begin
        prev_board <= board;
        undo_avail <= 1'b1;
      end
    end else if (undo) begin
      undo_avail <= 1'b0;
    end
  end
`else
  logic undo_unused;
  assign undo_unused = undo;
`endif

  // Board, change pulse and saturating move counter; priority clear > update > undo.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      board         <= INIT_BOARD;
      move_count    <= '0;
      board_changed <= 1'b0;
    end else begin
      board_changed <= 1'b0;
      if (clear) begin
        board      <= INIT_BOARD;
        move_count <= '0;
      end else if (update) begin
        board <= newvalues;
        if (altering) begin
          board_changed <= 1'b1;
          if (move_count != MAXC) move_count <= move_count + ONE;
        end
      end
`ifdef BOARD_STORE_UNDO_EN
      else if (undo && undo_avail) begin
        board <= prev_board;
        if (move_count != '0) move_count <= move_count - ONE;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      empty_count <= empty_of(INIT_BOARD);
      max_tile    <= max_of(INIT_BOARD);
    end else begin
      empty_count <= empty_of(board);
      max_tile    <= max_of(board);
    end
  end

  // Reads sample the register before any same-edge load lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= 4'd0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= tile_of(board, rd_addr);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_state <= S_IDLE;
      scan_ptr   <= 4'd0;
      snap       <= 64'd0;
    end else if (clear) begin
      scan_state <= S_IDLE;
      scan_ptr   <= 4'd0;
    end else if (scan_state == S_IDLE) begin
      if (scan_start) begin
        scan_state <= S_SCAN;
        scan_ptr   <= 4'd0;
        snap       <= board;
      end
    end else begin
      scan_ptr <= scan_ptr + 4'd1;
      if (scan_ptr == 4'd15) scan_state <= S_IDLE;
    end
  end

  assign scan_busy  = (scan_state == S_SCAN);
  assign scan_valid = scan_busy;
  assign scan_idx   = scan_busy ? scan_ptr : 4'd0;
  assign scan_data  = scan_busy ? tile_of(snap, scan_ptr) : 4'd0;
  assign scan_last  = scan_busy && (scan_ptr == 4'd15);

endmodule

// File: tb/tb_board_store.sv
// Testbench for board_store: directed steps plus randomized traffic against a tile-level model.
module tb_board_store;

`ifdef BOARD_STORE_UNDO_EN
  localparam bit UNDO_ON = 1'b1;
`else
  localparam bit UNDO_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        update, clear, rd_req, scan_start, undo;
  logic [63:0] newvalues;
  logic [3:0]  rd_addr;

  logic [63:0] oldvalues, s_oldvalues;
  logic        board_changed, s_board_changed;
  logic [15:0] move_count;
  logic [1:0]  s_move_count;
  logic [4:0]  empty_count, s_empty_count;
  logic [3:0]  max_tile, s_max_tile;
  logic        rd_valid, s_rd_valid;
  logic [3:0]  rd_data, s_rd_data;
  logic        scan_busy, scan_valid, scan_last, s_scan_busy, s_scan_valid, s_scan_last;
  logic [3:0]  scan_idx, scan_data, s_scan_idx, s_scan_data;
  logic [0:0]  scan_state, s_scan_state;

  always #5 clock = ~clock;

  board_store dut (
    .clock(clock), .reset_n(reset_n), .update(update), .newvalues(newvalues), .clear(clear),
    .oldvalues(oldvalues), .board_changed(board_changed), .move_count(move_count),
    .empty_count(empty_count), .max_tile(max_tile), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .scan_start(scan_start), .scan_busy(scan_busy),
    .scan_valid(scan_valid), .scan_idx(scan_idx), .scan_data(scan_data), .scan_last(scan_last),
    .undo(undo), .scan_state(scan_state)
  );

  board_store #(.MOVE_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .update(update), .newvalues(newvalues), .clear(clear),
    .oldvalues(s_oldvalues), .board_changed(s_board_changed), .move_count(s_move_count),
    .empty_count(s_empty_count), .max_tile(s_max_tile), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .scan_start(scan_start), .scan_busy(s_scan_busy),
    .scan_valid(s_scan_valid), .scan_idx(s_scan_idx), .scan_data(s_scan_data), .scan_last(s_scan_last),
    .undo(undo), .scan_state(s_scan_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: board as plain 64-bit value, scan as a queue of {idx,data} beats.
  logic [63:0] m_board, m_prev, m_stat;
  bit          m_avail, m_changed, m_rd_valid;
  logic [3:0]  m_rd_data;
  int          m_cnt, m_cnt_s;
  logic [7:0]  scan_q[$];

  function automatic int tile_m(input logic [63:0] b, input int i);
    return int'((b >> (4 * (15 - i))) & 64'hF);
  endfunction

  function automatic int empty_m(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (tile_m(b, i) == 0) n++;
    return n;
  endfunction

  function automatic int max_m(input logic [63:0] b);
    int m = 0;
    for (int i = 0; i < 16; i++) if (tile_m(b, i) > m) m = tile_m(b, i);
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit busy;
    busy = (scan_q.size() > 0);
    check("oldvalues", oldvalues, m_board);
    check("sat_oldvalues", s_oldvalues, m_board);
    check("board_changed", {63'd0, board_changed}, {63'd0, m_changed});
    check("move_count", {48'd0, move_count}, 64'(m_cnt));
    check("sat_move_count", {62'd0, s_move_count}, 64'(m_cnt_s));
    check("empty_count", {59'd0, empty_count}, 64'(empty_m(m_stat)));
    check("max_tile", {60'd0, max_tile}, 64'(max_m(m_stat)));
    check("rd_valid", {63'd0, rd_valid}, {63'd0, m_rd_valid});
    check("rd_data", {60'd0, rd_data}, {60'd0, m_rd_data});
    check("scan_busy", {63'd0, scan_busy}, {63'd0, busy});
    check("scan_valid", {63'd0, scan_valid}, {63'd0, busy});
    check("scan_idx", {60'd0, scan_idx}, busy ? {60'd0, scan_q[0][7:4]} : 64'd0);
    check("scan_data", {60'd0, scan_data}, busy ? {60'd0, scan_q[0][3:0]} : 64'd0);
    check("scan_last", {63'd0, scan_last}, {63'd0, busy && scan_q[0][7:4] == 4'd15});
  endtask

  task automatic idle_inputs();
    update = 0; clear = 0; rd_req = 0; scan_start = 0; undo = 0;
    newvalues = 64'd0; rd_addr = 4'd0;
  endtask

  // Advance the model by one edge using the inputs currently driven, then compare.
  task automatic tick();
    logic [63:0] pre;
    pre = m_board;
    m_rd_valid = rd_req;
    if (rd_req) m_rd_data = 4'(tile_m(pre, int'(rd_addr)));
    if (clear) scan_q.delete();
    else if (scan_q.size() > 0) void'(scan_q.pop_front());
    else if (scan_start)
      for (int i = 0; i < 16; i++) scan_q.push_back({4'(i), 4'(tile_m(pre, i))});
    m_changed = 0;
    if (clear) begin
      m_board = 64'd0; m_cnt = 0; m_cnt_s = 0; m_avail = 0;
    end else if (update) begin
      if (newvalues != pre) begin
        m_changed = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
        m_prev = pre;
        m_avail = 1;
      end
      m_board = newvalues;
    end else if (UNDO_ON && undo && m_avail) begin
      m_board = m_prev;
      if (m_cnt > 0) m_cnt--;
      if (m_cnt_s > 0) m_cnt_s--;
      m_avail = 0;
    end
    m_stat = pre;
    @(posedge clock);
    #1;
    check_all();
    idle_inputs();
  endtask

  function automatic logic [63:0] rand_board();
    logic [63:0] b;
    b = 64'd0;
    for (int i = 0; i < 16; i++)
      if ($urandom_range(0, 2) == 0) b[4*i +: 4] = 4'($urandom_range(1, 11));
    return b;
  endfunction

  int beats, lasts;
  logic [63:0] board_a;

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    m_board = 64'd0; m_prev = 64'd0; m_stat = 64'd0;
    m_avail = 0; m_changed = 0; m_rd_valid = 0; m_rd_data = 4'd0;
    m_cnt = 0; m_cnt_s = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all();
    check("reset_empty", {59'd0, empty_count}, 64'd16);
    check("reset_max", {60'd0, max_tile}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // First altering load, stats two edges later, then an identical load.
    update = 1; newvalues = 64'h1000_0000_0000_0002;
    tick();
    check("load_pulse", {63'd0, board_changed}, 64'd1);
    check("load_count", {48'd0, move_count}, 64'd1);
    tick();
    check("stat_empty14", {59'd0, empty_count}, 64'd14);
    check("stat_max2", {60'd0, max_tile}, 64'd2);
    update = 1; newvalues = 64'h1000_0000_0000_0002;
    tick();
    check("same_no_pulse", {63'd0, board_changed}, 64'd0);
    check("same_count", {48'd0, move_count}, 64'd1);

    // Read colliding with an update returns the old value.
    rd_req = 1; rd_addr = 4'd15; update = 1; newvalues = 64'h1000_0000_0000_0005;
    tick();
    check("rd_old", {60'd0, rd_data}, 64'd2);
    rd_req = 1; rd_addr = 4'd15;
    tick();
    check("rd_new", {60'd0, rd_data}, 64'd5);

    // Scan with a mid-scan load and an ignored restart.
    beats = 0; lasts = 0;
    scan_start = 1;
    tick();
    for (int c = 0; c < 20; c++) begin
      if (scan_valid) beats++;
      if (scan_last) lasts++;
      if (c == 3) begin update = 1; newvalues = 64'h2222_3333_4444_5555; end
      if (c == 5) scan_start = 1;
      tick();
    end
    check("scan_beats", 64'(beats), 64'd16);
    check("scan_lasts", 64'(lasts), 64'd1);

    // Saturate the narrow counter.
    for (int k = 0; k < 4; k++) begin
      update = 1; newvalues = 64'h0000_0000_0000_1000 + 64'(k);
      tick();
    end
    check("sat_hold3", {62'd0, s_move_count}, 64'd3);

    // Clear during a scan.
    scan_start = 1;
    tick();
    tick(); tick();
    clear = 1; update = 1; newvalues = 64'hFFFF;
    tick();
    check("clear_busy", {63'd0, scan_busy}, 64'd0);
    check("clear_board", oldvalues, 64'd0);
    check("clear_count", {48'd0, move_count}, 64'd0);

    // Undo: load A, load B, undo twice.
    board_a = 64'h0000_0001_0000_0000;
    update = 1; newvalues = board_a; tick();
    update = 1; newvalues = 64'h0000_0002_0000_0003; tick();
    undo = 1; tick();
`ifdef BOARD_STORE_UNDO_EN
    check("undo_board", oldvalues, board_a);
    check("undo_count", {48'd0, move_count}, 64'd1);
`else
    check("undo_ignored", oldvalues, 64'h0000_0002_0000_0003);
    check("undo_ignored_count", {48'd0, move_count}, 64'd2);
`endif
    undo = 1; tick();
    undo = 1; tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      clear      = ($urandom_range(0, 63) == 0);
      update     = ($urandom_range(0, 3) == 0);
      newvalues  = ($urandom_range(0, 3) == 0) ? m_board : rand_board();
      undo       = ($urandom_range(0, 5) == 0);
      rd_req     = ($urandom_range(0, 1) == 1);
      rd_addr    = 4'($urandom_range(0, 15));
      scan_start = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
